dmem_responder: RTL and testbench

Data-memory responder for the pipelined MIPS core. It services load/store requests issued from the EX/MEM stage over a valid/ready request channel with a fixed, parameterised wait-state latency. It returns read data and completion over a one-cycle response pulse, and raises `busy` so the hazard logic can stall the pipeline while an access is outstanding. It replaces the zero-latency combinational data memory with a model of a realistic slow memory.

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_array.sv | 26 ++
 rtl/dmem_responder.sv | 123 ++++++++++++
 tb/tb_dmem_responder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_t;

  localparam int DMEM_WAIT_W          = 4;
  localparam int DMEM_DEPTH_DEF       = 256;
  localparam int DMEM_WAIT_CYCLES_DEF = 2;

endpackage

// File: rtl/dmem_array.sv
// DEPTHx32 word storage: synchronous write, combinational read, async active-low clear.
module dmem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder: valid/ready request, one-cycle response pulse, busy stall.
// Optional DMEM_ALIGN_CHECK_EN: misaligned byte addresses are suppressed with resp_err.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = DMEM_DEPTH_DEF,
  parameter int WAIT_CYCLES = DMEM_WAIT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [DMEM_WAIT_W-1:0] LP_CNT_LOAD =
    (WAIT_CYCLES == 0) ? '0 : DMEM_WAIT_W'(WAIT_CYCLES - 1);

  dmem_state_t            r_state, w_state_nxt;
  logic [DMEM_WAIT_W-1:0] r_cnt, w_cnt_nxt;
  logic                   r_write;
  logic [31:0]            r_addr, r_wdata, r_rdata;
  logic                   r_err;

  logic                   w_accept, w_access, w_op_write, w_oor, w_err, w_we;
  logic [31:0]            w_op_addr, w_op_wdata, w_arr_rdata;
  logic [AW-1:0]          w_idx;

  assign w_accept = (r_state == ST_IDLE) && req_valid;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_access    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (WAIT_CYCLES == 0) begin
            w_access    = 1'b1;
            w_state_nxt = ST_RESP;
          end else begin
            w_cnt_nxt   = LP_CNT_LOAD;
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_access    = 1'b1;
          w_state_nxt = ST_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Zero-wait accesses happen on the acceptance edge, so they use the live request.
  assign w_op_write = (r_state == ST_IDLE) ? req_write : r_write;
  assign w_op_addr  = (r_state == ST_IDLE) ? req_addr  : r_addr;
  assign w_op_wdata = (r_state == ST_IDLE) ? req_wdata : r_wdata;

  assign w_idx = w_op_addr[2 +: AW];
  assign w_oor = (w_op_addr >> (AW + 2)) != '0;
`ifdef DMEM_ALIGN_CHECK_EN
  assign w_err = w_oor || (w_op_addr[1:0] != 2'b00);
`else
  assign w_err = w_oor;
`endif
  assign w_we  = w_access && w_op_write && !w_err;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_we    (w_we),
    .i_addr  (w_idx),
    .i_wdata (w_op_wdata),
    .o_rdata (w_arr_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (w_access) begin
        r_rdata <= (w_op_write || w_err) ? 32'd0 : w_arr_rdata;
        r_err   <= w_err;
      end
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = (r_state == ST_RESP);
  assign busy       = (r_state != ST_IDLE);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (WAIT_CYCLES 2, 0, 1) sharing clock and reset.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int W2    = 2;
  localparam int W0    = 0;
  localparam int W1    = 1;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALN = 1'b1;
`else
  localparam bit ALN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        s2_valid = 0, s2_write = 0, s2_ready, s2_rvalid, s2_err, s2_busy;
  logic [31:0] s2_addr = 0, s2_wdata = 0, s2_rdata;
  logic        s0_valid = 0, s0_write = 0, s0_ready, s0_rvalid, s0_err, s0_busy;
  logic [31:0] s0_addr = 0, s0_wdata = 0, s0_rdata;
  logic        s1_valid = 0, s1_write = 0, s1_ready, s1_rvalid, s1_err, s1_busy;
  logic [31:0] s1_addr = 0, s1_wdata = 0, s1_rdata;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W2)) u_dut2 (
    .clk(clk), .reset(rst_n), .req_valid(s2_valid), .req_write(s2_write),
    .req_addr(s2_addr), .req_wdata(s2_wdata), .req_ready(s2_ready),
    .resp_valid(s2_rvalid), .resp_rdata(s2_rdata), .resp_err(s2_err), .busy(s2_busy));

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W0)) u_dut0 (
    .clk(clk), .reset(rst_n), .req_valid(s0_valid), .req_write(s0_write),
    .req_addr(s0_addr), .req_wdata(s0_wdata), .req_ready(s0_ready),
    .resp_valid(s0_rvalid), .resp_rdata(s0_rdata), .resp_err(s0_err), .busy(s0_busy));

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W1)) u_dut1 (
    .clk(clk), .reset(rst_n), .req_valid(s1_valid), .req_write(s1_write),
    .req_addr(s1_addr), .req_wdata(s1_wdata), .req_ready(s1_ready),
    .resp_valid(s1_rvalid), .resp_rdata(s1_rdata), .resp_err(s1_err), .busy(s1_busy));

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference memory for the WAIT_CYCLES=2 instance: plain word array, byte address / 4.
  logic [31:0] m_mem [DEPTH];

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
  endtask

  task automatic model(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er);
    er = (a >= 32'(DEPTH * 4));
    if (ALN && (a % 4 != 0)) er = 1'b1;
    rd = '0;
    if (!er) begin
      if (w) m_mem[a / 4] = d;
      else   rd = m_mem[a / 4];
    end
  endtask

  // One request on the WAIT_CYCLES=2 instance; lat counts negedges after acceptance until resp_valid.
  task automatic txn2(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int lat, output int nbusy);
    @(negedge clk);
    s2_valid = 1'b1; s2_write = w; s2_addr = a; s2_wdata = d;
    @(posedge clk);
    #1 s2_valid = 1'b0;
    lat = 0; nbusy = 0; rd = '0; er = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (s2_busy && !s2_ready) nbusy++;
      if (s2_rvalid) begin
        lat = i; rd = s2_rdata; er = s2_err;
        break;
      end
    end
  endtask

  task automatic run2(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_er);
    logic [31:0] rd;
    logic        er;
    int          lat, nbusy;
    txn2(w, a, d, rd, er, lat, nbusy);
    check({tag, " rdata"}, rd, exp_rd);
    check({tag, " err"}, {31'd0, er}, {31'd0, exp_er});
    check({tag, " latency"}, 32'(lat), 32'(W2 + 1));
    check({tag, " busy cycles"}, 32'(nbusy), 32'(W2 + 1));
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rd;
    logic        er;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[$];
    logic [31:0] mrd, a, d;
    logic        mer, w;
    int          acc_mask, busy_mask, exp_mask, nxt_ok, n_resp, n_rv;

    model_clear();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst ready",  {31'd0, s2_ready},  32'd1);
    check("rst rvalid", {31'd0, s2_rvalid}, 32'd0);
    check("rst rdata",  s2_rdata,           32'd0);
    check("rst err",    {31'd0, s2_err},    32'd0);
    check("rst busy",   {31'd0, s2_busy},   32'd0);
    rst_n = 1'b1;

    // Zero wait states: back-to-back loads of 0x0 and 0x4, one accept every 2 cycles
    @(negedge clk);
    s0_valid = 1'b1; s0_write = 1'b0; s0_addr = 32'h0;
    check("w0 c0 ready", {31'd0, s0_ready}, 32'd1);
    @(negedge clk);
    check("w0 c1 rvalid", {31'd0, s0_rvalid}, 32'd1);
    check("w0 c1 ready",  {31'd0, s0_ready},  32'd0);
    check("w0 c1 rdata",  s0_rdata,           32'd0);
    check("w0 c1 err",    {31'd0, s0_err},    32'd0);
    s0_addr = 32'h4;
    @(negedge clk);
    check("w0 c2 ready",  {31'd0, s0_ready},  32'd1);
    check("w0 c2 rvalid", {31'd0, s0_rvalid}, 32'd0);
    @(negedge clk);
    check("w0 c3 rvalid", {31'd0, s0_rvalid}, 32'd1);
    check("w0 c3 rdata",  s0_rdata,           32'd0);
    s0_valid = 1'b0;
    @(negedge clk);
    check("w0 c4 rvalid", {31'd0, s0_rvalid}, 32'd0);
    check("w0 c4 busy",   {31'd0, s0_busy},   32'd0);

    // WAIT_CYCLES=1 with req_valid held high: accepts spaced WAIT+2 apart
    @(negedge clk);
    s1_valid = 1'b1; s1_write = 1'b0; s1_addr = 32'h0;
    acc_mask = 0; busy_mask = 0; exp_mask = 0; nxt_ok = 0; n_resp = 0;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) @(negedge clk);
      if (s1_ready) acc_mask |= (1 << c);
      if (s1_busy)  busy_mask |= (1 << c);
      if (s1_rvalid) n_resp++;
      if (c >= nxt_ok) begin
        exp_mask |= (1 << c);
        nxt_ok = c + W1 + 2;
      end
    end
    @(posedge clk);
    #1 s1_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (s1_rvalid) n_resp++;
    end
    check("w1 accept cycles", 32'(acc_mask), 32'(exp_mask));
    check("w1 accept cycles abs", 32'(acc_mask), 32'h49);
    check("w1 busy between", 32'(busy_mask), 32'(~exp_mask & 9'h1FF));
    check("w1 resp count", 32'(n_resp), 32'd3);

    // Directed table on the WAIT_CYCLES=2 instance
    tbl.push_back('{1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0});
    tbl.push_back('{1'b1, 32'h0,   32'h01020304, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 32'h400, 32'h0,        32'h0,        1'b1});
    tbl.push_back('{1'b1, 32'h400, 32'hFFFF0000, 32'h0,        1'b1});
    tbl.push_back('{1'b0, 32'h0,   32'h0,        32'h01020304, 1'b0});
    tbl.push_back('{1'b1, 32'h20,  32'hCAFEF00D, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 32'h22,  32'h0,        ALN ? 32'h0 : 32'hCAFEF00D, ALN});
    tbl.push_back('{1'b1, 32'h23,  32'h11111111, 32'h0,        ALN});
    tbl.push_back('{1'b0, 32'h20,  32'h0,        ALN ? 32'hCAFEF00D : 32'h11111111, 1'b0});
    tbl.push_back('{1'b0, 32'hFFFFFFFC, 32'h0,   32'h0,        1'b1});
    tbl.push_back('{1'b1, 32'h3FC, 32'h0BADF00D, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 32'h3FC, 32'h0,        32'h0BADF00D, 1'b0});
    for (int i = 0; i < tbl.size(); i++) begin
      model(tbl[i].w, tbl[i].a, tbl[i].d, mrd, mer);
      run2($sformatf("tbl%0d", i), tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].rd, tbl[i].er);
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 60; i++) begin
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      case ($urandom_range(0, 9))
        0:       a = $urandom | 32'h400;
        1:       a = 32'($urandom_range(0, 1023));
        default: a = 32'($urandom_range(0, 15)) * 4;
      endcase
      model(w, a, d, mrd, mer);
      run2($sformatf("rnd%0d", i), w, a, d, mrd, mer);
    end

    // Reset during WAIT drops the store and clears the array
    run2("pre-rst store", 1'b1, 32'h20, 32'hAAAA5555, 32'h0, 1'b0);
    @(negedge clk);
    s2_valid = 1'b1; s2_write = 1'b1; s2_addr = 32'h20; s2_wdata = 32'h12345678;
    @(posedge clk);
    #1 s2_valid = 1'b0;
    @(negedge clk);
    check("mid busy before rst", {31'd0, s2_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst busy drops", {31'd0, s2_busy},   32'd0);
    check("rst ready",      {31'd0, s2_ready},  32'd1);
    n_rv = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (s2_rvalid) n_rv++;
    end
    rst_n = 1'b1;
    model_clear();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (s2_rvalid) n_rv++;
    end
    check("rst no resp", 32'(n_rv), 32'd0);
    run2("post-rst load 0x20", 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);
    run2("post-rst load 0x10", 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
